// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the six-position multiplexed 7-segment display scanner.
//   - Glyph constants are seg[6:0] = {g,f,e,d,c,b,a}, active-low.
//   - Position numbers match the anode bit each position drives (an[pos] = 0).
//   - snapshot_t holds one captured display value (sign plus five BCD digits).
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_POS = 6;

    // Scan positions, in scan order.
    localparam logic [2:0] POS_HUNDTHS = 3'd0;
    localparam logic [2:0] POS_TENTHS  = 3'd1;
    localparam logic [2:0] POS_UNITS   = 3'd2;
    localparam logic [2:0] POS_TENS    = 3'd3;
    localparam logic [2:0] POS_HUND    = 3'd4;
    localparam logic [2:0] POS_SIGN    = 3'd5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [5:0] AN_OFF = 6'b111111;

    typedef struct packed {
        logic       sign;
        logic [3:0] d4;   // hundreds
        logic [3:0] d3;   // tens
        logic [3:0] d2;   // units
        logic [3:0] d1;   // tenths
        logic [3:0] d0;   // hundredths
    } snapshot_t;

    // Non-BCD codes (10-15) render blank rather than as hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler and scan-position counter for display_scan_ctrl.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   en    : 1 = count; 0 = hold prescaler and position
//   tick  : one-cycle pulse during the cycle whose edge advances the position
//   pos   : current scan position, 0..NUM_POS-1
module scan_tick_gen
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [2:0] pos
);

    localparam logic [19:0] CNT_LAST = 20'(PRESCALE - 1);

    logic [19:0] cnt_q;
    logic [2:0]  pos_q;

    assign tick = en && (cnt_q == CNT_LAST);
    assign pos  = pos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pos_q <= '0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                // >= rather than == so an upset into 6/7 recovers on the next wrap.
                if (pos_q >= POS_SIGN) begin
                    pos_q <= '0;
                end else begin
                    pos_q <= pos_q + 3'd1;
                end
            end else begin
                cnt_q <= cnt_q + 20'd1;
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 6-position 7-segment display controller for a signed value
// of the form -ddd.dd.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : 1 = scan; 0 = blank the display and freeze the scan
//   load     : capture sign_in/d4_in..d0_in on this edge
//   sign_in  : 1 = negative
//   d4_in..d0_in : BCD hundreds, tens, units, tenths, hundredths
//   load_ack : one-cycle pulse the cycle after a capture
//   an       : active-low anodes; an[0] = hundredths .. an[4] = hundreds, an[5] = sign
//   seg      : active-low segments {g..a}
//   dp       : active-low decimal point, lit at the units position
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic       sign_in,
    input  logic [3:0] d4_in,
    input  logic [3:0] d3_in,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic       load_ack,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic       tick;
    logic [2:0] pos;

    scan_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_scan_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick),
        .pos (pos)
    );

    // The display path follows pos directly; tick is not needed here.
    logic unused_tick;
    assign unused_tick = tick;

    // Snapshot capture and acknowledge.
    snapshot_t snap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q   <= '0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= load;
            if (load) begin
                snap_q <= '{sign: sign_in, d4: d4_in, d3: d3_in, d2: d2_in,
                            d1: d1_in, d0: d0_in};
            end
        end
    end

    // Leading-zero suppression and sign decision.
    logic hund_blank;
    logic tens_blank;
    logic show_minus;

    assign hund_blank = (snap_q.d4 == 4'd0);
    assign tens_blank = hund_blank && (snap_q.d3 == 4'd0);
    // A negative zero shows no minus sign.
    assign show_minus = snap_q.sign &&
                        ({snap_q.d4, snap_q.d3, snap_q.d2, snap_q.d1, snap_q.d0} != 20'd0);

    logic [5:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (pos)
            POS_HUNDTHS: begin
                an_d  = 6'b111110;
                seg_d = bcd_to_seg(snap_q.d0);
            end
            POS_TENTHS: begin
                an_d  = 6'b111101;
                seg_d = bcd_to_seg(snap_q.d1);
            end
            POS_UNITS: begin
                an_d  = 6'b111011;
                seg_d = bcd_to_seg(snap_q.d2);
                dp_d  = 1'b0;
            end
            POS_TENS: begin
                an_d = 6'b110111;
                if (!tens_blank) begin
                    seg_d = bcd_to_seg(snap_q.d3);
                end
            end
            POS_HUND: begin
                an_d = 6'b101111;
                if (!hund_blank) begin
                    seg_d = bcd_to_seg(snap_q.d4);
                end
            end
            POS_SIGN: begin
                an_d = 6'b011111;
                if (show_minus) begin
                    seg_d = SEG_DASH;
                end
            end
            default: begin
                an_d = AN_OFF;
            end
        endcase
    end

    // Registered display outputs; en=0 blanks everything from the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (!en) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with PRESCALE=4.
module tb_display_scan_ctrl;

    localparam int unsigned PRESCALE = 4;
    localparam logic [14:0] RESET_EXP = {6'b111111, 7'b1111111, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       sign_in = 1'b0;
    logic [3:0] d_in [5];
    logic       load_ack;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_n = 0;

    logic [14:0] exp_q[$];

    // Reference model state: enabled-cycle count and captured value.
    int ecount = 0;
    bit m_sign = 1'b0;
    int m_d [5];

    display_scan_ctrl #(
        .PRESCALE(PRESCALE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .sign_in (sign_in),
        .d4_in   (d_in[4]),
        .d3_in   (d_in[3]),
        .d2_in   (d_in[2]),
        .d1_in   (d_in[1]),
        .d0_in   (d_in[0]),
        .load_ack(load_ack),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic string letters_of(int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            default: return "abcdfg";
        endcase
    endfunction

    // Active-low segment vector (bit 0 = a .. bit 6 = g) from lit-segment letters.
    function automatic logic [6:0] seg_from_letters(string s);
        logic [6:0] r;
        r = 7'b1111111;
        for (int i = 0; i < s.len(); i++) begin
            r[int'(s[i]) - 97] = 1'b0;
        end
        return r;
    endfunction

    // Character a reader sees at display position p (0 = hundredths .. 5 = sign).
    function automatic byte disp_char(int p);
        bit any_nz;
        any_nz = 1'b0;
        for (int i = 0; i < 5; i++) if (m_d[i] != 0) any_nz = 1'b1;
        if (p == 5) return (m_sign && any_nz) ? byte'(45) : byte'(32);
        if (p == 4 && m_d[4] == 0) return byte'(32);
        if (p == 3 && m_d[4] == 0 && m_d[3] == 0) return byte'(32);
        if (m_d[p] > 9) return byte'(32);
        return byte'(48 + m_d[p]);
    endfunction

    function automatic logic [6:0] glyph(byte c);
        if (c == byte'(32)) return 7'b1111111;
        if (c == byte'(45)) return seg_from_letters("g");
        return seg_from_letters(letters_of(int'(c) - 48));
    endfunction

    task automatic check(string name, logic [14:0] act, logic [14:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b ack=%b, expected an=%b seg=%b dp=%b ack=%b",
                     name, act[14:9], act[8:2], act[1], act[0],
                     expv[14:9], expv[8:2], expv[1], expv[0]);
        end
    endtask

    // Model: at each edge, predict what the outputs become after it.
    initial begin : model
        int p;
        logic [5:0] a;
        logic [14:0] e;
        for (int i = 0; i < 5; i++) m_d[i] = 0;
        forever begin
            @(posedge clk);
            cyc_n++;
            if (rst) begin
                ecount = 0;
                m_sign = 1'b0;
                for (int i = 0; i < 5; i++) m_d[i] = 0;
                exp_q.push_back(RESET_EXP);
            end else begin
                p = (ecount / PRESCALE) % 6;
                if (en) begin
                    a = 6'b111111;
                    a[p] = 1'b0;
                    e = {a, glyph(disp_char(p)), (p == 2) ? 1'b0 : 1'b1, load};
                    ecount++;
                end else begin
                    e = {6'b111111, 7'b1111111, 1'b1, load};
                end
                exp_q.push_back(e);
                if (load) begin
                    m_sign = sign_in;
                    for (int i = 0; i < 5; i++) m_d[i] = int'(d_in[i]);
                end
            end
        end
    end

    // Monitor: compare outputs mid-cycle; a reset asserted since the edge overrides.
    initial begin : monitor
        logic [14:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rst) e = RESET_EXP;
                check($sformatf("cycle %0d", cyc_n), {an, seg, dp, load_ack}, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic set_val(bit s, int d4, int d3, int d2, int d1, int d0);
        sign_in = s;
        d_in[4] = 4'(d4);
        d_in[3] = 4'(d3);
        d_in[2] = 4'(d2);
        d_in[1] = 4'(d1);
        d_in[0] = 4'(d0);
    endtask

    task automatic do_load(bit s, int d4, int d3, int d2, int d1, int d0);
        set_val(s, d4, d3, d2, d1, d0);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // Bounded wait until the model's scan sits at position p with the given count phase.
    task automatic wait_pos(int p, int phase, string name);
        int k;
        k = 0;
        while (!(((ecount / PRESCALE) % 6) == p && (ecount % PRESCALE) == phase) && k < 200) begin
            cyc();
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: position %0d phase %0d not reached in 200 cycles", name, p, phase);
        end
    endtask

    initial begin : main
        set_val(1'b0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        en  = 1'b1;
        run(3);
        rst = 1'b0;

        // Zero after reset: "0.00" with blanks.
        run(2 * 6 * PRESCALE);

        do_load(1'b1, 1, 2, 7, 5, 0);
        run(30);
        do_load(1'b1, 0, 0, 5, 0, 0);
        run(30);
        do_load(1'b1, 0, 0, 0, 0, 0);
        run(30);

        // Freeze at position 3 mid-slot, then resume.
        do_load(1'b0, 3, 4, 5, 6, 7);
        wait_pos(3, 1, "reach pos 3");
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(30);

        // Back-to-back loads, then a load landing on a prescaler wrap.
        set_val(1'b1, 9, 8, 7, 6, 5);
        load = 1'b1;
        cyc();
        set_val(1'b0, 0, 4, 0, 0, 1);
        cyc();
        set_val(1'b1, 0, 0, 0, 0, 3);
        cyc();
        load = 1'b0;
        run(10);
        wait_pos(4, PRESCALE - 1, "reach wrap");
        do_load(1'b1, 2, 0, 1, 12, 9);
        run(30);

        // Randomized traffic, including non-BCD codes.
        for (int i = 0; i < 1200; i++) begin
            int v [5];
            for (int j = 0; j < 5; j++) begin
                if ($urandom_range(0, 19) == 0) v[j] = int'($urandom_range(10, 15));
                else if ($urandom_range(0, 2) == 0) v[j] = 0;
                else v[j] = int'($urandom_range(0, 9));
            end
            set_val(1'($urandom_range(0, 1)), v[4], v[3], v[2], v[1], v[0]);
            load = ($urandom_range(0, 4) == 0);
            en = ($urandom_range(0, 9) != 0);
            cyc();
        end
        load = 1'b0;
        en = 1'b1;

        // Asynchronous reset mid-scan coinciding with a load.
        do_load(1'b1, 1, 1, 1, 1, 1);
        run(7);
        set_val(1'b1, 9, 9, 9, 9, 9);
        load = 1'b1;
        rst = 1'b1;
        #1;
        check("async reset immediate", {an, seg, dp, load_ack}, RESET_EXP);
        load = 1'b0;
        run(2);
        rst = 1'b0;
        run(30);

        // A load on the reset-release cycle is captured.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        set_val(1'b1, 0, 6, 0, 2, 5);
        load = 1'b1;
        cyc();
        load = 1'b0;
        run(30);

        run(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have a parameter PRESCALE, default 50000, giving clock cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  1 = scanning active; 0 = display blanked, scan frozen.
REQ-005 load  input  1  single-cycle strobe; capture digit inputs this cycle.
REQ-006 sign_in  input  1  1 = negative value.
REQ-007 d4_in..d0_in  input  4 each  BCD digits: hundreds, tens, units, tenths, hundredths.
REQ-008 load_ack  output  1  one-cycle pulse on the cycle after a capture.
REQ-009 an  output  6  digit enables, active-low; an[0] = hundredths ... an[4] = hundreds, an[5] = sign position.
REQ-010 seg  output  7  segments g..a, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 A 20-bit prescaler SHALL count 0..PRESCALE-1 while en=1; on reaching PRESCALE-1 it wraps to 0 and the 3-bit position advances 0,1,2,3,4,5,0.
REQ-013 Position 5 wrap-around SHALL return to 0; values 6-7 SHALL never occur.
REQ-014 With en=0, the prescaler and position SHALL hold their values, and an, seg and dp SHALL be driven all-ones from the next cycle.
REQ-015 On a rising edge with load=1, the snapshot registers (sign, d4..d0) SHALL take the inputs; load_ack SHALL be 1 for exactly the following cycle.
REQ-016 Load SHALL be accepted every cycle regardless of en or position; back-to-back loads SHALL each capture and each produce a load_ack.
REQ-017 Outputs SHALL be registered from current position and snapshot: a value captured at edge k appears on seg at edge k+1 when its position is active.
REQ-018 Blanking rule: hundreds blank when d4=0; tens blank when d4=0 and d3=0; units, tenths and hundredths are always shown.
REQ-019 The sign position SHALL show "-" (only segment g lit) when sign=1 and any digit is nonzero; otherwise it is blank.
REQ-020 A negative zero (sign=1, all digits 0) SHALL display as "0.00" with no minus.
REQ-021 dp SHALL be 0 only while position 2 (units) is active; it is 1 otherwise.
REQ-022 A BCD digit value of 10-15 SHALL render as blank (seg all ones); no error flag is raised.
REQ-023 Exactly one an bit SHALL be 0 when en=1; an SHALL be 6'b111111 for blank positions except the digit's anode.
REQ-024 A blank position SHALL still assert its anode, with seg all ones.
REQ-025 A load coinciding with a prescaler wrap SHALL apply both: the new position is displayed using the new snapshot from the next edge.

Reset
REQ-026 While rst=1, the block SHALL hold: prescaler=0, position=0, snapshot=0 (sign 0, digits 0), load_ack=0, an=6'b111111, seg=7'b1111111, dp=1.
REQ-027 Reset assertion mid-scan or mid-load SHALL take effect immediately (asynchronously); a load on the release cycle is captured normally.
REQ-028 After reset with en=1, the first displayed digit SHALL be position 0 showing "0" one cycle after reset release.

Structure
REQ-029 A shared package SHALL hold the 7-segment glyph constants (0-9, dash, blank), the position constants POS_HUND..POS_SIGN, and the NUM_POS=6 constant.
REQ-030 The prescaler and position counter SHALL form one sub-module, scan_tick_gen, outputting a one-cycle tick.
REQ-031 The blanking decision and glyph decode SHALL be combinational inside display_scan_ctrl, feeding the output registers.

Verification (bench uses PRESCALE=4)
REQ-032 Reset release with en=1 and no load -> an cycles 111110, 111101, ..., 011111 every 4 cycles; seg shows "0","0","0" then blank, blank, blank; dp=0 only at an=111011.
REQ-033 load with sign=1 and digits 1,2,7,5,0 (-127.50) -> load_ack pulses once; the display shows "-", "1", "2", "7.", "5", "0".
REQ-034 load with sign=1 and digits 0,0,5,0,0 (-5.00) -> hundreds and tens blank; the sign position shows "-"; units show "5" with dp=0.
REQ-035 load with sign=1 and all digits 0 -> the sign position is blank; "0.00" is displayed.
REQ-036 en dropped to 0 at position 3 for 10 cycles, then raised -> all outputs are ones during the gap; scanning resumes at position 3 with its prescaler count preserved.
REQ-037 rst asserted mid-scan while load=1 on the same cycle -> the outputs go to their reset values immediately, the snapshot reads zero, and no load_ack is generated.
